// File: rtl/proc_pkg.sv
// Shared widths, opcode/timestep encodings and IR field positions for the processor control path.
package proc_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned NREG   = 4;
  localparam int unsigned REG_W  = $clog2(NREG);

  localparam int unsigned OP_LSB = 8;
  localparam int unsigned RX_LSB = 6;
  localparam int unsigned RY_LSB = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  function automatic logic [NREG-1:0] reg_sel(input logic [REG_W-1:0] r);
    logic [NREG-1:0] sel;
    sel    = '0;
    sel[r] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge pulse from a synchronised level input.
module rise_detect (
  input  logic CLK,
  input  logic RST,
  input  logic in_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in_i;
    end
  end

  assign pulse_o = in_i & ~prev_q;

endmodule

// File: rtl/proc_control_unit.sv
// Timestep sequencer and strobe decoder for the four-register datapath.
// Optional manual stepping of T1..T3 is enabled by defining PROC_STEP_MODE_EN.
module proc_control_unit
  import proc_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EXEC,
`ifdef PROC_STEP_MODE_EN
  input  logic              STEP,
`endif
  input  logic [DATA_W-1:0] INSTR,
  output logic [NREG-1:0]   RIN,
  output logic [NREG-1:0]   ROUT,
  output logic              DIN_OUT,
  output logic              AIN,
  output logic              GIN,
  output logic              GOUT,
  output logic              ADDSUB,
  output logic [1:0]        TIME,
  output logic              BUSY,
  output logic              DONE,
  output logic              DONE_HOLD
);

  tstep_e            time_q;
  logic [DATA_W-1:0] ir_q;
  logic              done_hold_q;
  logic              exec_pulse;
  logic              advance;
  op_e               op;
  logic [REG_W-1:0]  rx;
  logic [REG_W-1:0]  ry;
  logic              unused_ir_lsb;

  rise_detect u_exec_rise (
    .CLK     (CLK),
    .RST     (RST),
    .in_i    (EXEC),
    .pulse_o (exec_pulse)
  );

`ifdef PROC_STEP_MODE_EN
  logic step_pulse;

  rise_detect u_step_rise (
    .CLK     (CLK),
    .RST     (RST),
    .in_i    (STEP),
    .pulse_o (step_pulse)
  );

  assign advance = step_pulse;
`else
  assign advance = 1'b1;
`endif

  assign op            = op_e'(ir_q[OP_LSB +: 2]);
  assign rx            = ir_q[RX_LSB +: REG_W];
  assign ry            = ir_q[RY_LSB +: REG_W];
  assign unused_ir_lsb = ^ir_q[RY_LSB-1:0];

  // EXEC edges outside T0 fall through unhandled, so they are dropped rather than queued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      time_q      <= T0;
      ir_q        <= '0;
      done_hold_q <= 1'b0;
    end else begin
      unique case (time_q)
        T0: begin
          if (exec_pulse) begin
            ir_q        <= INSTR;
            time_q      <= T1;
            done_hold_q <= 1'b0;
          end
        end
        T1: begin
          if (advance) begin
            if (op == OP_ADD || op == OP_SUB) begin
              time_q <= T2;
            end else begin
              time_q      <= T0;
              done_hold_q <= 1'b1;
            end
          end
        end
        T2: begin
          if (advance) begin
            time_q <= T3;
          end
        end
        T3: begin
          if (advance) begin
            time_q      <= T0;
            done_hold_q <= 1'b1;
          end
        end
        default: time_q <= T0;
      endcase
    end
  end

  // Strobes come only from registered state, so reset clears them without waiting for a clock.
  always_comb begin
    RIN     = '0;
    ROUT    = '0;
    DIN_OUT = 1'b0;
    AIN     = 1'b0;
    GIN     = 1'b0;
    GOUT    = 1'b0;
    ADDSUB  = 1'b0;
    DONE    = 1'b0;
    unique case (time_q)
      T1: begin
        unique case (op)
          OP_LOAD: begin
            DIN_OUT = 1'b1;
            RIN     = reg_sel(rx);
            DONE    = 1'b1;
          end
          OP_MOV: begin
            ROUT = reg_sel(ry);
            RIN  = reg_sel(rx);
            DONE = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ROUT = reg_sel(rx);
            AIN  = 1'b1;
          end
          default: ;
        endcase
      end
      T2: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ROUT   = reg_sel(ry);
          GIN    = 1'b1;
          ADDSUB = ir_q[OP_LSB];
        end
      end
      T3: begin
        if (op == OP_ADD || op == OP_SUB) begin
          GOUT = 1'b1;
          RIN  = reg_sel(rx);
          DONE = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign TIME      = time_q;
  assign BUSY      = (time_q != T0);
  assign DONE_HOLD = done_hold_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit against a transfer-level instruction model.
module tb_proc_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EXEC;
  logic       STEP;
  logic [9:0] INSTR;
  logic [3:0] RIN;
  logic [3:0] ROUT;
  logic       DIN_OUT;
  logic       AIN;
  logic       GIN;
  logic       GOUT;
  logic       ADDSUB;
  logic [1:0] TIME;
  logic       BUSY;
  logic       DONE;
  logic       DONE_HOLD;

  int n_run  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  proc_control_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .EXEC      (EXEC),
`ifdef PROC_STEP_MODE_EN
    .STEP      (STEP),
`endif
    .INSTR     (INSTR),
    .RIN       (RIN),
    .ROUT      (ROUT),
    .DIN_OUT   (DIN_OUT),
    .AIN       (AIN),
    .GIN       (GIN),
    .GOUT      (GOUT),
    .ADDSUB    (ADDSUB),
    .TIME      (TIME),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DONE_HOLD (DONE_HOLD)
  );

  // Packed view: {RIN, ROUT, DIN_OUT, AIN, GIN, GOUT, ADDSUB, TIME, BUSY, DONE, DONE_HOLD}
  function automatic logic [17:0] obs_vec();
    return {RIN, ROUT, DIN_OUT, AIN, GIN, GOUT, ADDSUB, TIME, BUSY, DONE, DONE_HOLD};
  endfunction

  function automatic int n_steps(input logic [9:0] instr);
    return instr[9] ? 3 : 1;
  endfunction

  // Each timestep is one bus transfer: a source driving the bus and a destination loading it.
  // Step 0 means idle, where only the sticky done flag may be set.
  function automatic logic [17:0] model(input logic [9:0] instr, input int s, input logic dh);
    logic [3:0] rin, rout, selx, sely;
    logic       din, ain, gin, gout, sub, done;
    selx = 4'b0001 << instr[7:6];
    sely = 4'b0001 << instr[5:4];
    rin  = '0;
    rout = '0;
    {din, ain, gin, gout, sub, done} = '0;
    if (s == 0) return {13'b0, 2'b00, 1'b0, 1'b0, dh};
    if (!instr[9]) begin
      if (instr[8]) rout = sely;
      else          din  = 1'b1;
      rin  = selx;
      done = 1'b1;
    end else if (s == 1) begin
      rout = selx;
      ain  = 1'b1;
    end else if (s == 2) begin
      rout = sely;
      gin  = 1'b1;
      sub  = instr[8];
    end else begin
      gout = 1'b1;
      rin  = selx;
      done = 1'b1;
    end
    return {rin, rout, din, ain, gin, gout, sub, 2'(s), 1'b1, done, 1'b0};
  endfunction

  // Issue one instruction; EXEC stays high for hold extra cycles, optionally re-rising in T2.
  task automatic run_instr(input logic [9:0] instr, input int hold, input bit reedge,
                           input string name);
    logic [17:0] e, o;
    int n, total;
    n     = n_steps(instr);
    total = ((hold > n) ? hold : n) + 1;
    @(negedge CLK);
    INSTR = instr;
    EXEC  = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(negedge CLK);
      o = obs_vec();
      e = (k <= n) ? model(instr, k, 1'b0) : model(instr, 0, 1'b1);
      n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s step %0d: got %b expected %b", name, k, o, e);
      end
      n_run++;
      if ($countones({ROUT, DIN_OUT, GOUT}) > 1) begin
        n_fail++;
        $display("FAIL %s bus_excl step %0d: drivers %b expected at most one", name, k,
                 {ROUT, DIN_OUT, GOUT});
      end
      EXEC  = (k <= hold) || (reedge && k == 2);
      INSTR = 10'($urandom);
    end
    EXEC = 1'b0;
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    EXEC  = 1'b0;
    STEP  = 1'b0;
    INSTR = '0;
    #1;
    n_run++;
    if (obs_vec() !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs_vec(), 18'b0);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_run++;
    if (obs_vec() !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs_vec(), 18'b0);
    end
  endtask

  task automatic test_directed();
    run_instr(10'b00_01_000000, 0, 1'b0, "load_r1");
    run_instr(10'b01_10_11_0000, 0, 1'b0, "mov_r2_r3");
    run_instr(10'b11_00_01_0000, 0, 1'b0, "sub_r0_r1");
    run_instr(10'b10_11_11_0000, 0, 1'b0, "add_r3_r3");
    run_instr(10'b01_00_00_1111, 0, 1'b0, "mov_r0_r0");
  endtask

  task automatic test_exec_hold();
    run_instr(10'b10_01_10_0000, 10, 1'b0, "add_exec_held");
    run_instr(10'b10_10_01_0000, 0, 1'b1, "add_reedge_t2");
    run_instr(10'b00_11_000000, 6, 1'b0, "load_exec_held");
  endtask

  task automatic test_reset_mid();
    logic [9:0]  instr;
    logic [17:0] e;
    instr = 10'b10_10_11_0000;
    @(negedge CLK);
    INSTR = instr;
    EXEC  = 1'b1;
    @(negedge CLK);
    EXEC = 1'b0;
    @(negedge CLK);
    e = model(instr, 2, 1'b0);
    n_run++;
    if (obs_vec() !== e) begin
      n_fail++;
      $display("FAIL rst_mid_t2: got %b expected %b", obs_vec(), e);
    end
    RST = 1'b1;
    #1;
    n_run++;
    if (obs_vec() !== 18'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %b expected %b", obs_vec(), 18'b0);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_run++;
      if (obs_vec() !== 18'b0) begin
        n_fail++;
        $display("FAIL rst_mid_after %0d: got %b expected %b", k, obs_vec(), 18'b0);
      end
    end
    run_instr(10'b11_01_00_0000, 0, 1'b0, "sub_after_rst");
  endtask

  task automatic test_random();
    logic [9:0] instr;
    int         hold;
    bit         reedge;
    for (int i = 0; i < 30; i++) begin
      instr  = 10'($urandom);
      hold   = $urandom_range(0, 5);
      reedge = instr[9] && ($urandom_range(0, 1) == 1);
      run_instr(instr, hold, reedge, "random");
    end
  endtask

`ifdef PROC_STEP_MODE_EN
  task automatic test_step_mode();
    logic [9:0]  instr;
    logic [17:0] e;
    instr = 10'b10_01_10_0000;
    @(negedge CLK);
    INSTR = instr;
    EXEC  = 1'b1;
    @(negedge CLK);
    EXEC = 1'b0;
    e = model(instr, 1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      n_run++;
      if (obs_vec() !== e) begin
        n_fail++;
        $display("FAIL step_hold_t1 %0d: got %b expected %b", k, obs_vec(), e);
      end
      @(negedge CLK);
    end
    for (int s = 2; s <= 4; s++) begin
      STEP = 1'b1;
      @(negedge CLK);
      STEP = 1'b0;
      e = (s <= 3) ? model(instr, s, 1'b0) : model(instr, 0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_run++;
        if (obs_vec() !== e) begin
          n_fail++;
          $display("FAIL step_adv s%0d k%0d: got %b expected %b", s, k, obs_vec(), e);
        end
        @(negedge CLK);
      end
    end
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
    @(negedge CLK);
    e = model(instr, 0, 1'b1);
    n_run++;
    if (obs_vec() !== e) begin
      n_fail++;
      $display("FAIL step_in_t0: got %b expected %b", obs_vec(), e);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PROC_STEP_MODE_EN
    test_step_mode();
`else
    test_directed();
    test_exec_hold();
    test_reset_mid();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Timestep sequencer for the 10-bit, four-register processor datapath.
- Decodes one instruction per EXEC press and drives the datapath control strobes: register in/out enables, DIN and G bus drivers, A/G latches, add/sub select.
- Its TIME and DONE outputs feed the display/output logic, which shows the timestep on HEX5 and the completion dot.

Parameters:
DATA_W, 10, data bus and instruction width
NREG, 4, number of general registers (R0..R3); fixes the register-field width at 2 bits

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
EXEC  input  1  synchronised run key, level; rising edge starts an instruction
INSTR  input  DATA_W  instruction word: [9:8] OP, [7:6] Rx, [5:4] Ry, [3:0] ignored
RIN  output  NREG  one-hot register load enables
ROUT  output  NREG  one-hot register bus-drive enables
DIN_OUT  output  1  DIN drives bus
AIN  output  1  load A latch
GIN  output  1  load G latch
GOUT  output  1  G drives bus
ADDSUB  output  1  ALU op: 0=add, 1=sub
TIME  output  2  current timestep T0..T3
BUSY  output  1  instruction in flight (TIME != T0)
DONE  output  1  final-timestep pulse, one cycle
DONE_HOLD  output  1  sticky done, for the HEX5 dot

Behaviour:
- Reset state (asynchronous): TIME=T0, IR=0, all strobes 0, BUSY=0, DONE=0, DONE_HOLD=0, edge register=0.
- EXEC rising edge detected internally: a registered copy of EXEC, edge = EXEC & ~prev.
- Holding EXEC starts exactly one instruction.
- At T0 with an edge present:
  - IR <= INSTR
  - TIME <= T1
  - DONE_HOLD <= 0
- Edges while BUSY are ignored and not queued.
- All strobes are decoded combinationally from TIME and IR, never from live INSTR.
- Strobes are asserted for exactly one cycle per timestep.
- At most one bus driver is active in any cycle: ROUT, DIN_OUT and GOUT are mutually exclusive.
- OP=00 LOAD:
  - T1: DIN_OUT, RIN[Rx], DONE
  - return to T0
- OP=01 MOV:
  - T1: ROUT[Ry], RIN[Rx], DONE
  - return to T0
- OP=10 ADD / OP=11 SUB:
  - T1: ROUT[Rx], AIN
  - T2: ROUT[Ry], GIN, ADDSUB=OP[0]
  - T3: GOUT, RIN[Rx], DONE
  - return to T0
- Rx == Ry is legal:
  - MOV is a no-op copy.
  - ADD doubles; SUB yields 0.
- DONE_HOLD is set on the cycle after DONE. It clears on the next accepted EXEC edge or on RST.
- Latency: LOAD/MOV take 2 cycles from edge to DONE, measured from edge cycle to T1. ADD/SUB take 4 cycles.
- RST mid-instruction: immediate return to T0, all strobes drop asynchronously, no partial register write after release.
- ADDSUB=0 outside T2.

Optional Feature:
- Macro: PROC_STEP_MODE_EN
- Defined:
  - Adds input STEP (1 bit, synchronised key). Its rising edge is detected the same way as EXEC.
  - Leaving T1, T2 or T3 requires a STEP edge; TIME holds otherwise.
  - Strobes and DONE stay asserted for the whole held timestep.
  - DONE_HOLD sets when the final timestep is left.
  - The EXEC edge still performs T0 -> T1. A STEP edge in T0 is ignored.
- Undefined: no STEP port; timesteps advance every clock as described above.

Decomposition:
- Package proc_pkg: DATA_W, NREG, opcode enum (OP_LOAD, OP_MOV, OP_ADD, OP_SUB), timestep enum (T0..T3), IR field slice constants.
- Sub-module rise_detect (CLK, RST, in, pulse): reused for EXEC and, in step mode, STEP.
- The FSM and decode stay in proc_control_unit.

Test Plan:
- Reset, then EXEC edge with INSTR=10'b00_01_000000 (LOAD R1) -> next cycle TIME=1, DIN_OUT=1, RIN=4'b0010, DONE=1; following cycle TIME=0, DONE_HOLD=1.
- INSTR=10'b01_10_11_0000 (MOV R2,R3) -> T1: ROUT=4'b1000, RIN=4'b0100, DONE=1; no other strobe.
- INSTR=10'b11_00_01_0000 (SUB R0,R1) -> T1: ROUT=0001, AIN; T2: ROUT=0010, GIN, ADDSUB=1; T3: GOUT, RIN=0001, DONE; 4 cycles total.
- EXEC held high for 10 cycles, and a second EXEC edge during T2 of an ADD -> exactly one instruction executes; IR unchanged mid-op.
- RST asserted in T2 of ADD -> TIME=0, all strobes 0 in the same cycle, DONE_HOLD=0; a fresh EXEC edge after release runs normally.
- With PROC_STEP_MODE_EN defined: ADD, no STEP for 20 cycles -> TIME stays 1, AIN held; three STEP edges -> T2, T3, T0.
